// File: rtl/vga_frame_signature.sv
// VGA output monitor: checks line/frame timing and signs the active area of N
// consecutive frames with CRC-32 (poly 04C11DB7, init all-ones, MSB first).
module vga_frame_signature #(
  parameter int RGB_W    = 8,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b0,
  parameter int FRM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic [RGB_W-1:0] rgb,
  input  logic             arm,
  input  logic [FRM_W-1:0] n_frames,
  output logic             busy,
  output logic             done,
  output logic             sig_valid,
  output logic [31:0]      sig,
  output logic [FRM_W-1:0] frame_idx,
  output logic [31:0]      pix_count,
  output logic             timing_err,
  output logic [1:0]       err_code
);
  // one spare code above the total so a missing sync saturates past the check value
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] H_LO   = HW'(H_START);
  localparam logic [HW-1:0] H_HI   = HW'(H_START + H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LO   = VW'(V_START);
  localparam logic [VW-1:0] V_HI   = VW'(V_START + V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [31:0]   POLY   = 32'h04C1_1DB7;

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAP, DONE} state_t;
  state_t state, state_nxt;

  logic             hs_q, vs_q, hchk;
  logic [HW-1:0]    hcnt, hcnt_nxt;
  logic [VW-1:0]    vcnt, vcnt_nxt;
  logic [31:0]      crc, crc_base, crc_nxt, pcnt, pcnt_nxt;
  logic [FRM_W-1:0] nlat, fcnt;
  logic             hs_edge, vs_edge, active, arm_ok, last;

  function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [RGB_W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = RGB_W - 1; i >= 0; i--)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction

  assign hs_edge = pix_en && (h_sync == SYNC_POL) && (hs_q != SYNC_POL);
  assign vs_edge = pix_en && (v_sync == SYNC_POL) && (vs_q != SYNC_POL);
  assign arm_ok  = arm && (state == IDLE || state == DONE);
  assign last    = (fcnt == nlat - 1'b1);

  // counter values that belong to the current sample
  always_comb begin
    hcnt_nxt = hcnt;
    vcnt_nxt = vcnt;
    if (pix_en) begin
      if (hs_edge)            hcnt_nxt = '0;
      else if (hcnt != '1)    hcnt_nxt = hcnt + 1'b1;
      if (vs_edge)            vcnt_nxt = '0;
      else if (hs_edge && vcnt != '1) vcnt_nxt = vcnt + 1'b1;
      if (vs_edge && state == WAIT_VS) hcnt_nxt = '0;
    end
  end

  always_comb begin
    active   = pix_en && (hcnt_nxt >= H_LO) && (hcnt_nxt < H_HI)
                      && (vcnt_nxt >= V_LO) && (vcnt_nxt < V_HI);
    crc_base = vs_edge ? 32'hFFFF_FFFF : crc;
    crc_nxt  = active ? crc_fold(crc_base, rgb) : crc_base;
    pcnt_nxt = (vs_edge ? 32'd0 : pcnt) + {31'd0, active};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm_ok) state_nxt = WAIT_VS;
      WAIT_VS: if (vs_edge) state_nxt = CAP;
      CAP:     if (vs_edge && last) state_nxt = DONE;
      DONE:    state_nxt = arm_ok ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q <= SYNC_POL;  vs_q <= SYNC_POL;
      hcnt <= '0;  vcnt <= '0;  hchk <= 1'b0;
      crc <= '0;  pcnt <= '0;  nlat <= '0;  fcnt <= '0;
      done <= 1'b0;  sig_valid <= 1'b0;  sig <= '0;
      frame_idx <= '0;  pix_count <= '0;  err_code <= '0;
    end else begin
      sig_valid <= 1'b0;
      if (pix_en) begin
        hs_q <= h_sync;  vs_q <= v_sync;
        hcnt <= hcnt_nxt;  vcnt <= vcnt_nxt;
      end
      if (arm_ok) begin
        nlat      <= (n_frames == '0) ? FRM_W'(1) : n_frames;
        fcnt      <= '0;
        done      <= 1'b0;
        err_code  <= '0;
        frame_idx <= '0;
      end
      if (state == WAIT_VS && vs_edge) begin
        crc  <= crc_nxt;
        pcnt <= pcnt_nxt;
        // a line already under way at capture start is not length-checked
        hchk <= hs_edge;
      end
      if (state == CAP && pix_en) begin
        crc  <= crc_nxt;
        pcnt <= pcnt_nxt;
        if (hs_edge) begin
          if (hchk && hcnt != H_LAST) err_code[0] <= 1'b1;
          hchk <= 1'b1;
        end
        if (vs_edge) begin
          if (vcnt != V_LAST) err_code[1] <= 1'b1;
          sig       <= crc;
          pix_count <= pcnt;
          frame_idx <= fcnt;
          fcnt      <= fcnt + 1'b1;
          sig_valid <= 1'b1;
          if (last) done <= 1'b1;
        end
      end
    end
  end

  assign busy       = (state == WAIT_VS) || (state == CAP);
  assign timing_err = |err_code;
endmodule

// File: tb/tb_vga_frame_signature.sv
// Directed bench on a shrunken 10x6 raster with a 4x3 active area (h 2..5, lines 1..3).
module tb_vga_frame_signature;
  localparam int HT = 10;

  logic        clk = 1'b0, rst = 1'b0, pix_en = 1'b0, h_sync = 1'b1, v_sync = 1'b1, arm = 1'b0;
  logic [7:0]  rgb = '0, n_frames = '0;
  logic        busy, done, sig_valid, timing_err;
  logic [31:0] sig, pix_count;
  logic [7:0]  frame_idx;
  logic [1:0]  err_code;

  int checks = 0, failures = 0, duty = 100;
  logic [31:0] q_sig[$], q_pc[$], q_idx[$];
  logic [31:0] m, sig_a;

  vga_frame_signature #(
    .RGB_W(8), .H_TOTAL(HT), .V_TOTAL(6), .H_START(2), .H_ACTIVE(4),
    .V_START(1), .V_ACTIVE(3), .SYNC_POL(1'b0), .FRM_W(8)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync), .rgb(rgb),
    .arm(arm), .n_frames(n_frames), .busy(busy), .done(done), .sig_valid(sig_valid),
    .sig(sig), .frame_idx(frame_idx), .pix_count(pix_count),
    .timing_err(timing_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (sig_valid) begin
      q_sig.push_back(sig);
      q_pc.push_back(pix_count);
      q_idx.push_back({24'd0, frame_idx});
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [31:0] frame_crc(input bit cnst, input logic [7:0] base);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 12; i++) c = crc8(c, cnst ? base : base + 8'(i));
    return c;
  endfunction

  task automatic pix(input logic hs, input logic vs, input logic [7:0] d);
    while (duty < 100 && $urandom_range(0, 99) >= duty) begin
      pix_en = 1'b0;
      @(posedge clk); #1;
    end
    h_sync = hs; v_sync = vs; rgb = d; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  task automatic frame(input int lines, input int short_ln, input bit cnst, input logic [7:0] base);
    int ord, len;
    bit act;
    ord = 0;
    for (int l = 0; l < lines; l++) begin
      len = (l == short_ln) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        act = (h >= 2) && (h < 6) && (l >= 1) && (l < 4);
        pix(h >= 2, l != 0, act ? (cnst ? base : base + 8'(ord)) : 8'h00);
        if (act) ord++;
      end
    end
  endtask

  task automatic arm_pulse(input logic [7:0] n);
    n_frames = n; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic close_run();
    pix(1'b0, 1'b0, 8'h00);
    pix(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic clr_q();
    q_sig.delete(); q_pc.delete(); q_idx.delete();
  endtask

  initial begin
    // model sanity: CRC-32/MPEG-2 check value of "123456789"
    m = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) m = crc8(m, 8'h31 + 8'(i));
    chk("model_ref", m, 32'h0376_E6E7);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_sv", {31'd0, sig_valid}, 0);
    chk("rst_sig", sig, 0);
    chk("rst_pc", pix_count, 0);
    chk("rst_err", {29'd0, timing_err, err_code}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: two clean frames, constant pixel
    clr_q();
    arm_pulse(8'd2);
    chk("t1_busy", {31'd0, busy}, 1);
    pix(1'b1, 1'b1, 8'h00);
    frame(6, -1, 1'b1, 8'h5A);
    frame(6, -1, 1'b1, 8'h5A);
    close_run();
    wait_done("t1_done");
    chk("t1_nsv", q_sig.size(), 2);
    if (q_sig.size() == 2) begin
      m = frame_crc(1'b1, 8'h5A);
      chk("t1_sig0", q_sig[0], m);
      chk("t1_sig1", q_sig[1], m);
      chk("t1_pc0", q_pc[0], 12);
      chk("t1_pc1", q_pc[1], 12);
      chk("t1_idx0", q_idx[0], 0);
      chk("t1_idx1", q_idx[1], 1);
    end
    chk("t1_busy_end", {31'd0, busy}, 0);
    chk("t1_err", {29'd0, timing_err, err_code}, 0);

    // 2: pixel ordinal stream
    clr_q();
    arm_pulse(8'd1);
    pix(1'b1, 1'b1, 8'h00);
    frame(6, -1, 1'b0, 8'h00);
    close_run();
    wait_done("t2_done");
    chk("t2_nsv", q_sig.size(), 1);
    if (q_sig.size() == 1) begin
      chk("t2_sig", q_sig[0], frame_crc(1'b0, 8'h00));
      chk("t2_pc", q_pc[0], 12);
    end

    // 3: line 2 one slot short
    clr_q();
    arm_pulse(8'd1);
    pix(1'b1, 1'b1, 8'h00);
    frame(6, 2, 1'b0, 8'h40);
    close_run();
    wait_done("t3_done");
    chk("t3_err", {30'd0, err_code}, 32'b01);
    chk("t3_terr", {31'd0, timing_err}, 1);
    chk("t3_nsv", q_sig.size(), 1);
    if (q_sig.size() == 1) chk("t3_sig", q_sig[0], frame_crc(1'b0, 8'h40));

    // 4: seven lines in a frame, then re-arm clears flags
    clr_q();
    arm_pulse(8'd1);
    pix(1'b1, 1'b1, 8'h00);
    frame(7, -1, 1'b1, 8'h77);
    close_run();
    wait_done("t4_done");
    chk("t4_err", {30'd0, err_code}, 32'b10);
    arm_pulse(8'd1);
    chk("t4_rearm_done", {31'd0, done}, 0);
    chk("t4_rearm_err", {29'd0, timing_err, err_code}, 0);
    chk("t4_rearm_busy", {31'd0, busy}, 1);
    pix(1'b1, 1'b1, 8'h00);
    frame(6, -1, 1'b1, 8'h77);
    close_run();
    wait_done("t4_done2");
    chk("t4_err2", {30'd0, err_code}, 0);

    // 5: full duty with an ignored arm during busy, then 30% duty, same stream
    clr_q();
    arm_pulse(8'd1);
    pix(1'b1, 1'b1, 8'h00);
    arm_pulse(8'd3);
    frame(6, -1, 1'b0, 8'h90);
    close_run();
    frame(6, -1, 1'b0, 8'h90);
    close_run();
    wait_done("t5_done_a");
    chk("t5_nsv_a", q_sig.size(), 1);
    sig_a = (q_sig.size() > 0) ? q_sig[0] : 32'hDEAD_BEEF;
    chk("t5_sig_a", sig_a, frame_crc(1'b0, 8'h90));
    clr_q();
    duty = 30;
    arm_pulse(8'd1);
    pix(1'b1, 1'b1, 8'h00);
    frame(6, -1, 1'b0, 8'h90);
    close_run();
    duty = 100;
    wait_done("t5_done_b");
    chk("t5_nsv_b", q_sig.size(), 1);
    if (q_sig.size() == 1) chk("t5_sig_b", q_sig[0], sig_a);

    // 6: reset mid-frame, then n_frames=0 signs exactly one frame
    clr_q();
    arm_pulse(8'd2);
    pix(1'b1, 1'b1, 8'h00);
    for (int h = 0; h < 25; h++) pix((h % HT) >= 2, h >= HT, 8'h11);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_out", {sig[15:0], pix_count[7:0], frame_idx}, 0);
    chk("t6_flags", {28'd0, done, timing_err, err_code}, 0);
    chk("t6_nsv", q_sig.size(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    arm_pulse(8'd0);
    pix(1'b1, 1'b1, 8'h00);
    frame(6, -1, 1'b0, 8'h20);
    frame(6, -1, 1'b0, 8'h20);
    close_run();
    wait_done("t6_done");
    chk("t6_nsv2", q_sig.size(), 1);
    if (q_sig.size() == 1) begin
      chk("t6_sig", q_sig[0], frame_crc(1'b0, 8'h20));
      chk("t6_idx", q_idx[0], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
